// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and mode sequencing for the button-driven LED controller.
package led_ctrl_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_OFF:  next_mode = MODE_ON;
      MODE_ON:   next_mode = MODE_SLOW;
      MODE_SLOW: next_mode = MODE_FAST;
      default:   next_mode = MODE_OFF;
    endcase
  endfunction

  function automatic logic is_blink(input logic [1:0] m);
    is_blink = (m == MODE_SLOW) || (m == MODE_FAST);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus consecutive-mismatch debounce counter.
// db_flip flags the cycle whose rising edge will toggle btn_db.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic btn_db,
  output logic db_flip
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] db_cnt;

  assign db_flip = (s2 != btn_db) && (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous here, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
      if (db_flip) begin
        btn_db <= s2;
        db_cnt <= '0;
      end else if (s2 != btn_db) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// Button-driven LED controller: short/long press classification, mode FSM
// (OFF, ON, SLOW_BLINK, FAST_BLINK) and a registered blinking LED drive.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 20,
  parameter int SLOW_HALF         = 8,
  parameter int FAST_HALF         = 2,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic       led,
  output logic [1:0] mode,
  output logic       short_press,
  output logic       long_press
);

  logic             btn_db;
  logic             db_flip;
  logic             db_fall;
  logic [CNT_W-1:0] hold_cnt,  hold_nxt;
  logic             long_done, long_done_nxt;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;
  logic             blink_ph,  blink_ph_nxt;
  logic [CNT_W-1:0] half_m1;
  logic [1:0]       mode_nxt;
  logic             short_nxt, long_nxt, led_nxt;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .button  (button),
    .btn_db  (btn_db),
    .db_flip (db_flip)
  );

  // The release is acted on at the same edge the debounced level drops.
  assign db_fall = db_flip & btn_db;
  assign half_m1 = (mode == MODE_SLOW) ? CNT_W'(SLOW_HALF - 1) : CNT_W'(FAST_HALF - 1);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    mode_nxt      = mode;
    short_nxt     = 1'b0;
    long_nxt      = 1'b0;
    hold_nxt      = hold_cnt;
    long_done_nxt = long_done;

    if (btn_db && !long_done) begin
      if (hold_cnt == CNT_W'(LONG_PRESS_CYCLES - 1)) begin
        long_nxt      = 1'b1;
        mode_nxt      = MODE_OFF;
        long_done_nxt = 1'b1;
      end else begin
        hold_nxt = hold_cnt + 1'b1;
      end
    end

    // A hold that completes on the release edge still counts as long.
    if (db_fall) begin
      if (!long_done && !long_nxt) begin
        short_nxt = 1'b1;
        mode_nxt  = next_mode(mode);
      end
      hold_nxt      = '0;
      long_done_nxt = 1'b0;
    end

    blink_cnt_nxt = blink_cnt;
    blink_ph_nxt  = blink_ph;
    if (mode_nxt != mode) begin
      blink_cnt_nxt = '0;
      blink_ph_nxt  = 1'b1;
    end else if (is_blink(mode)) begin
      if (blink_cnt == half_m1) begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt_nxt = '0;
    end

    case (mode_nxt)
      MODE_OFF: led_nxt = 1'b0;
      MODE_ON:  led_nxt = 1'b1;
      default:  led_nxt = blink_ph_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode        <= MODE_OFF;
      led         <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
    end else begin
      mode        <= mode_nxt;
      led         <= led_nxt;
      short_press <= short_nxt;
      long_press  <= long_nxt;
      hold_cnt    <= hold_nxt;
      long_done   <= long_done_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_ph    <= blink_ph_nxt;
    end
  end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Button-driven LED controller. It takes a raw push-button input, synchronises and debounces it, and classifies each press as short or long. A mode FSM sequences the LED through OFF, ON, SLOW_BLINK and FAST_BLINK. It is the control layer above the basic button/LED FSM and produces the registered LED drive plus status pulses for top-level logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised input must differ from the debounced level before the level flips; minimum 1.
- LONG_PRESS_CYCLES, 20: debounced-high cycles that make a press long; minimum 2.
- SLOW_HALF, 8: LED half-period in SLOW_BLINK, in cycles; minimum 1.
- FAST_HALF, 2: LED half-period in FAST_BLINK, in cycles; minimum 1.
- CNT_W, 16: width of all internal counters; must hold max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, SLOW_HALF).

Ports:
- clk, input, 1: single system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low (reset==0 resets on the next rising clk edge).
- button, input, 1: raw asynchronous button, 1 = pressed.
- led, output, 1: registered LED drive.
- mode, output, 2: current mode. 00 OFF, 01 ON, 10 SLOW_BLINK, 11 FAST_BLINK.
- short_press, output, 1: one-cycle pulse on release of a short press.
- long_press, output, 1: one-cycle pulse when the hold reaches LONG_PRESS_CYCLES.

Behaviour:
- Reset (reset==0 at a clk edge): led=0, mode=OFF, short_press=0, long_press=0. Sync flops=0, debounced level btn_db=0, all counters=0, long_done=0. Reset applied mid-press or mid-blink aborts everything; no pulse is emitted.
- Synchroniser: two flops s1 and s2; s2 lags button by 2 edges.
- Debounce:
  - While s2 != btn_db, db_cnt increments.
  - When db_cnt == DEBOUNCE_CYCLES-1 and still mismatched: btn_db <= s2 and db_cnt <= 0.
  - Any cycle with s2 == btn_db clears db_cnt, so glitches shorter than DEBOUNCE_CYCLES are ignored.
  - A clean button edge reaches btn_db exactly 2+DEBOUNCE_CYCLES edges later.
- Press classification:
  - While btn_db==1 and long_done==0, hold_cnt increments.
  - When hold_cnt reaches LONG_PRESS_CYCLES-1: long_press=1 for one cycle, mode <= OFF, long_done <= 1. Then hold_cnt stops.
  - On btn_db falling (1->0): if long_done==0, short_press=1 for one cycle and mode advances. In both cases hold_cnt <= 0 and long_done <= 0.
  - The rising edge of btn_db causes no action.
- Mode FSM:
  - A short press advances OFF->ON->SLOW_BLINK->FAST_BLINK->OFF (wraps).
  - A long press forces OFF from any mode, including OFF (pulse still emitted).
  - mode changes on the same edge as the short_press/long_press pulse.
- LED output:
  - OFF: led=0. ON: led=1.
  - Blink modes: led=blink_ph.
  - On every mode change, blink_cnt <= 0 and blink_ph <= 1, so a blink mode starts with led high on the same edge mode updates.
  - blink_cnt counts 0..HALF-1. At HALF-1, blink_ph toggles and blink_cnt wraps to 0, giving an exact period of 2*HALF.
  - In OFF and ON, blink_cnt is held at 0.
- Simultaneity: only one of short_press and long_press can fire in a cycle, by construction. Never both.

Decomposition:
- Package led_ctrl_pkg: mode encodings MODE_OFF, MODE_ON, MODE_SLOW, MODE_FAST as 2-bit localparams, plus next-mode function.
- Sub-module button_debounce (clk, reset, button, DEBOUNCE_CYCLES, CNT_W -> btn_db): synchroniser plus debounce counter.
- Classification, mode FSM and blinker stay in led_mode_ctrl.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with button=1 -> led=0, mode=00, no pulses. Release reset with button held -> normal debounce follows (btn_db rises 6 edges later with defaults).
2. Glitch rejection: button high for 3 cycles, then low -> btn_db never rises; mode stays 00; no pulses.
3. Short press cycle: four presses, each held 10 cycles -> per release one short_press pulse 6 edges after the button falls. mode goes 01, 10, 11, 00; led=1 in ON.
4. Blink timing: enter SLOW_BLINK -> led high 8 cycles, low 8, high 8. Next short press -> FAST_BLINK: led high 2, low 2, starting high on the mode-change edge.
5. Long press: from mode 10, hold button 40 cycles -> long_press pulse 20 cycles after btn_db rises, mode=00, led=0. Release -> no short_press, mode stays 00.
6. Reset mid-operation: in FAST_BLINK with button held 10 cycles, assert reset=0 for 1 cycle -> led=0, mode=00. The remaining hold is treated as a fresh press by debounce; no long_press pulse unless the hold completes 20 new debounced cycles.
